// File: rtl/motor_seq_ctrl_pkg.sv
// Shared types and default widths for the motor command sequencer.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DEAD  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam int REP_W_DEF  = 8;
    localparam int WDOG_W_DEF = 22;
    localparam int SPEED_W    = 3;

endpackage

// File: rtl/motor_seq_ctrl_timer.sv
// Loadable saturating down-counter; expire_o is high while the count sits at zero.
module cyc_timer #(
    parameter int W = 22
) (
    input  logic         div100_clk,
    input  logic         s_rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_ff @(posedge div100_clk or negedge s_rst_n) begin
        if (!s_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                          cnt_d = '0;
        else if (load_i)                    cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))    cnt_d = cnt_q - W'(1);
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/motor_seq_ctrl.sv
// Motion command sequencer feeding the PWM stage: repetition counting,
// dead-time on every stop/reversal, and a flag watchdog.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | PWM enabled, counting end-of-breath flags
// DEAD  | PWM disabled for the dead-time before resuming or finishing
// FAULT | flags stopped arriving; held until fault_clr
module motor_seq_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int DEADTIME_CYC = 50,
    parameter int WDOG_CYC     = 2100000,
    parameter int WDOG_W       = WDOG_W_DEF,
    parameter int REP_W        = REP_W_DEF
) (
    input  logic               div100_clk,
    input  logic               s_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [SPEED_W-1:0] cmd_speed,
    input  logic [REP_W-1:0]   cmd_reps,
    input  logic               cmd_pingpong,
    input  logic               stop_req,
    input  logic               fault_clr,
    input  logic               pwm_flag,
    output logic               pwm_enable,
    output logic               pwm_direct,
    output logic [SPEED_W-1:0] pwm_cnt,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               fault,
    output logic [REP_W-1:0]   reps_left
);

    state_e             state_q, state_d;
    logic               end_q, end_d;
    logic               abort_q, abort_d;
    logic               pp_q, pp_d;
    logic               reps_nz_q, reps_nz_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               fault_q, fault_d;
    logic               en_q, en_d;
    logic               dir_q, dir_d;
    logic [SPEED_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0]   reps_q, reps_d;

    logic wd_load, wd_dec, wd_exp;
    logic dt_load, dt_dec, dt_exp;
    logic end_now, abort_now;

    cyc_timer #(.W(WDOG_W)) u_wdog (
        .div100_clk (div100_clk),
        .s_rst_n    (s_rst_n),
        .clr_i      (state_q == FAULT),
        .load_i     (wd_load),
        .load_val_i (WDOG_W'(WDOG_CYC - 1)),
        .dec_i      (wd_dec),
        .expire_o   (wd_exp)
    );

    cyc_timer #(.W(WDOG_W)) u_dead (
        .div100_clk (div100_clk),
        .s_rst_n    (s_rst_n),
        .clr_i      (state_q == FAULT),
        .load_i     (dt_load),
        .load_val_i (WDOG_W'(DEADTIME_CYC - 1)),
        .dec_i      (dt_dec),
        .expire_o   (dt_exp)
    );

    always_ff @(posedge div100_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= IDLE;
            end_q     <= 1'b0;
            abort_q   <= 1'b0;
            pp_q      <= 1'b0;
            reps_nz_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            fault_q   <= 1'b0;
            en_q      <= 1'b0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            reps_q    <= '0;
        end else begin
            state_q   <= state_d;
            end_q     <= end_d;
            abort_q   <= abort_d;
            pp_q      <= pp_d;
            reps_nz_q <= reps_nz_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            fault_q   <= fault_d;
            en_q      <= en_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            reps_q    <= reps_d;
        end
    end

    // A stop seen during a mid-sequence dead-time converts it into an abort.
    assign end_now   = end_q | stop_req;
    assign abort_now = abort_q | (stop_req & ~end_q);

    always_comb begin
        state_d   = state_q;
        end_d     = end_q;
        abort_d   = abort_q;
        pp_d      = pp_q;
        reps_nz_d = reps_nz_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        fault_d   = fault_q;
        en_d      = en_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        reps_d    = reps_q;
        wd_load   = 1'b0;
        wd_dec    = 1'b0;
        dt_load   = 1'b0;
        dt_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d     = cmd_dir;
                    cnt_d     = cmd_speed;
                    reps_d    = cmd_reps;
                    reps_nz_d = (cmd_reps != '0);
                    pp_d      = cmd_pingpong;
                    end_d     = 1'b0;
                    abort_d   = 1'b0;
                    en_d      = 1'b1;
                    wd_load   = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (stop_req) begin
                    en_d    = 1'b0;
                    end_d   = 1'b1;
                    abort_d = 1'b1;
                    dt_load = 1'b1;
                    state_d = DEAD;
                end else if (pwm_flag) begin
                    wd_load = 1'b1;
                    if (reps_nz_q && (reps_q == REP_W'(1))) begin
                        reps_d  = '0;
                        en_d    = 1'b0;
                        end_d   = 1'b1;
                        abort_d = 1'b0;
                        dt_load = 1'b1;
                        state_d = DEAD;
                    end else begin
                        if (reps_q != '0) reps_d = reps_q - REP_W'(1);
                        if (pp_q) begin
                            en_d    = 1'b0;
                            dir_d   = ~dir_q;
                            end_d   = 1'b0;
                            dt_load = 1'b1;
                            state_d = DEAD;
                        end
                    end
                end else if (wd_exp) begin
                    en_d    = 1'b0;
                    dir_d   = 1'b0;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    wd_dec = 1'b1;
                end
            end
            DEAD: begin
                if (dt_exp) begin
                    if (end_now) begin
                        done_d    = 1'b1;
                        aborted_d = abort_now;
                        end_d     = 1'b0;
                        abort_d   = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        en_d    = 1'b1;
                        wd_load = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    dt_dec  = 1'b1;
                    end_d   = end_now;
                    abort_d = abort_now;
                end
            end
            FAULT: begin
                en_d  = 1'b0;
                dir_d = 1'b0;
                cnt_d = '0;
                if (fault_clr) begin
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign fault      = fault_q;
    assign pwm_enable = en_q;
    assign pwm_direct = dir_q;
    assign pwm_cnt    = cnt_q;
    assign reps_left  = reps_q;

endmodule

// File: tb/tb_motor_seq_ctrl.sv
// Bench for motor_seq_ctrl: directed scenarios plus random commands, every
// cycle compared against a rule-level behavioural model.
module tb_motor_seq_ctrl;

    localparam int DT = 4;
    localparam int WD = 20;

    logic       div100_clk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [2:0] cmd_speed = '0;
    logic [7:0] cmd_reps = '0;
    logic       cmd_pingpong = 1'b0;
    logic       stop_req = 1'b0;
    logic       fault_clr = 1'b0;
    logic       pwm_flag = 1'b0;
    logic       pwm_enable, pwm_direct, busy, done, aborted, fault;
    logic [2:0] pwm_cnt;
    logic [7:0] reps_left;

    always #5 div100_clk = ~div100_clk;

    motor_seq_ctrl #(.DEADTIME_CYC(DT), .WDOG_CYC(WD), .WDOG_W(22), .REP_W(8)) dut (
        .div100_clk(div100_clk), .s_rst_n(s_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_speed(cmd_speed), .cmd_reps(cmd_reps), .cmd_pingpong(cmd_pingpong),
        .stop_req(stop_req), .fault_clr(fault_clr), .pwm_flag(pwm_flag),
        .pwm_enable(pwm_enable), .pwm_direct(pwm_direct), .pwm_cnt(pwm_cnt),
        .busy(busy), .done(done), .aborted(aborted), .fault(fault),
        .reps_left(reps_left)
    );

    int total = 0;
    int bad = 0;

    // behavioural model: mode 0 idle, 1 running, 2 dead-time, 3 faulted
    int m_mode, m_age, m_dead, m_reps, m_reps_cap, m_cnt;
    bit m_pp, m_fin, m_ab, m_en, m_dir, m_fault, m_done, m_abo;

    int fc = 0;
    bit flag_en = 1'b1;
    bit force_flag = 1'b0;
    int flags_seen = 0;
    int low_busy = 0;
    int live_rev = 0;
    bit prev_en = 1'b0;
    bit prev_dir = 1'b0;
    bit ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] obs_vec();
        return {cmd_ready, busy, done, aborted, fault, pwm_enable, pwm_direct, pwm_cnt, reps_left};
    endfunction

    function automatic logic [17:0] exp_vec();
        return {m_mode == 0, m_mode != 0, m_done, m_abo, m_fault, m_en, m_dir,
                3'(m_cnt), 8'(m_reps)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_dead = 0; m_reps = 0; m_reps_cap = 0; m_cnt = 0;
        m_pp = 0; m_fin = 0; m_ab = 0; m_en = 0; m_dir = 0; m_fault = 0;
        m_done = 0; m_abo = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        m_abo = 0;
        case (m_mode)
            0: if (cmd_valid) begin
                m_en = 1; m_dir = cmd_dir; m_cnt = int'(cmd_speed);
                m_reps = int'(cmd_reps); m_reps_cap = m_reps; m_pp = cmd_pingpong;
                m_age = 0; m_fin = 0; m_ab = 0; m_mode = 1;
            end
            1: if (stop_req) begin
                m_en = 0; m_fin = 1; m_ab = 1; m_dead = DT; m_mode = 2;
            end else if (pwm_flag) begin
                m_age = 0;
                if (m_reps_cap != 0 && m_reps == 1) begin
                    m_reps = 0; m_en = 0; m_fin = 1; m_ab = 0; m_dead = DT; m_mode = 2;
                end else begin
                    if (m_reps > 0) m_reps--;
                    if (m_pp) begin
                        m_en = 0; m_dir = !m_dir; m_fin = 0; m_dead = DT; m_mode = 2;
                    end
                end
            end else if (m_age == WD - 1) begin
                m_en = 0; m_dir = 0; m_cnt = 0; m_fault = 1; m_mode = 3;
            end else begin
                m_age++;
            end
            2: begin
                if (stop_req && !m_fin) begin m_fin = 1; m_ab = 1; end
                m_dead--;
                if (m_dead == 0) begin
                    if (m_fin) begin
                        m_done = 1; m_abo = m_ab; m_mode = 0;
                    end else begin
                        m_en = 1; m_age = 0; m_mode = 1;
                    end
                end
            end
            default: if (fault_clr) begin m_fault = 0; m_mode = 0; end
        endcase
    endtask

    // flag source emulates the PWM stage: one pulse per 10 enabled cycles
    task automatic tick();
        if (pwm_enable === 1'b1) fc++;
        else fc = 0;
        pwm_flag = force_flag;
        if (flag_en && fc >= 10) begin
            pwm_flag = 1'b1;
            fc = 0;
        end
        if (pwm_flag) flags_seen++;
        model_step();
        @(posedge div100_clk);
        #1;
        chk("cycle", 32'(obs_vec()), 32'(exp_vec()));
        if (busy && !pwm_enable) low_busy++;
        if (prev_en && pwm_enable && (pwm_direct !== prev_dir)) live_rev++;
        prev_en = pwm_enable;
        prev_dir = pwm_direct;
        pwm_flag = 1'b0;
        force_flag = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_done(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            tick();
            if (done === 1'b1) found = 1'b1;
        end
    endtask

    task automatic send(input bit d, input int spd, input int reps, input bit pp);
        cmd_valid = 1'b1; cmd_dir = d; cmd_speed = 3'(spd);
        cmd_reps = 8'(reps); cmd_pingpong = pp;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2;
        s_rst_n = 1'b0;
        #1;
        model_reset();
        fc = 0;
        chk({tag, "_now"}, 32'(obs_vec()), 32'h20000);
        @(negedge div100_clk);
        s_rst_n = 1'b1;
        @(posedge div100_clk);
        #1;
        chk({tag, "_rel"}, 32'(obs_vec()), 32'(exp_vec()));
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        prev_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge div100_clk);
        @(negedge div100_clk);
        s_rst_n = 1'b1;
        @(posedge div100_clk);
        #1;
        chk("reset_vec", 32'(obs_vec()), 32'h20000);

        // three repetitions, forward, no ping-pong
        flags_seen = 0;
        send(1'b1, 5, 3, 1'b0);
        chk("s1_en", 32'(pwm_enable), 32'd1);
        chk("s1_dir", 32'(pwm_direct), 32'd1);
        chk("s1_cnt", 32'(pwm_cnt), 32'd5);
        chk("s1_reps", 32'(reps_left), 32'd3);
        run_until_done(100, ok);
        chk("s1_done", 32'(ok), 32'd1);
        chk("s1_abort", 32'(aborted), 32'd0);
        chk("s1_flags", 32'(flags_seen), 32'd3);
        chk("s1_ready", 32'(cmd_ready), 32'd1);

        // ping-pong, two repetitions
        low_busy = 0; live_rev = 0;
        send(1'b0, 2, 2, 1'b1);
        chk("s2_dir0", 32'(pwm_direct), 32'd0);
        run_until_done(100, ok);
        chk("s2_done", 32'(ok), 32'd1);
        chk("s2_abort", 32'(aborted), 32'd0);
        chk("s2_lowcyc", 32'(low_busy), 32'd8);
        chk("s2_live_rev", 32'(live_rev), 32'd0);
        chk("s2_dir1", 32'(pwm_direct), 32'd1);

        // continuous, stop at cycle 35
        send(1'b1, 7, 0, 1'b0);
        ticks(34);
        chk("s3_reps0", 32'(reps_left), 32'd0);
        chk("s3_busy", 32'(busy), 32'd1);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        chk("s3_en_off", 32'(pwm_enable), 32'd0);
        ticks(3);
        chk("s3_no_done_yet", 32'(done), 32'd0);
        tick();
        chk("s3_done", 32'(done), 32'd1);
        chk("s3_abort", 32'(aborted), 32'd1);

        // stop and flag together: no decrement
        send(1'b0, 3, 5, 1'b0);
        ticks(5);
        stop_req = 1'b1; force_flag = 1'b1;
        tick();
        stop_req = 1'b0;
        chk("s4_reps_kept", 32'(reps_left), 32'd5);
        chk("s4_en_off", 32'(pwm_enable), 32'd0);
        run_until_done(20, ok);
        chk("s4_done", 32'(ok), 32'd1);
        chk("s4_abort", 32'(aborted), 32'd1);

        // watchdog fault
        flag_en = 1'b0;
        send(1'b1, 4, 2, 1'b0);
        ticks(19);
        chk("s5_no_fault_yet", 32'(fault), 32'd0);
        tick();
        chk("s5_fault", 32'(fault), 32'd1);
        chk("s5_en_off", 32'(pwm_enable), 32'd0);
        chk("s5_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        ticks(3);
        cmd_valid = 1'b0;
        chk("s5_ignore_cmd", 32'(fault), 32'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("s5_clr_ready", 32'(cmd_ready), 32'd1);
        chk("s5_clr_fault", 32'(fault), 32'd0);
        chk("s5_no_done", 32'(done), 32'd0);

        // flag in the watchdog expiry cycle restarts it
        send(1'b0, 1, 5, 1'b0);
        ticks(19);
        force_flag = 1'b1;
        tick();
        chk("s6_no_fault", 32'(fault), 32'd0);
        chk("s6_reps", 32'(reps_left), 32'd4);
        ticks(19);
        chk("s6_still_ok", 32'(fault), 32'd0);
        tick();
        chk("s6_fault", 32'(fault), 32'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        flag_en = 1'b1;

        // reset during RUN, then during DEAD
        send(1'b1, 6, 3, 1'b0);
        ticks(4);
        async_reset("s7_run");
        send(1'b0, 6, 3, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (busy && !pwm_enable) ok = 1'b1;
        end
        chk("s7_reach_dead", 32'(ok), 32'd1);
        tick();
        async_reset("s7_dead");

        // random commands with random stop/valid/fault_clr activity
        for (int n = 0; n < 25; n++) begin
            flag_en = ($urandom_range(0, 7) != 0);
            send(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            ok = 1'b0;
            for (int i = 0; i < 150 && !ok; i++) begin
                stop_req  = (i > 60) || ($urandom_range(0, 40) == 0);
                cmd_valid = ($urandom_range(0, 5) == 0);
                fault_clr = fault && ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 30) == 0) force_flag = 1'b1;
                tick();
                if (cmd_ready === 1'b1) ok = 1'b1;
            end
            stop_req = 1'b0; cmd_valid = 1'b0; fault_clr = 1'b0;
            chk("rand_idle", 32'(ok), 32'd1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_seq_ctrl.md
Name: motor_seq_ctrl

Overview:
Command sequencer directly upstream of the motor PWM stage. It accepts a motion command (direction, speed level, repetition count, ping-pong mode) over a valid/ready handshake and drives the PWM stage's enable/direct/cnt inputs. It counts the PWM stage's one-cycle end-of-breath flag pulses to retire repetitions and inserts dead-time on every direction change or stop. A watchdog faults the sequence if flags stop arriving.

Parameters:
DEADTIME_CYC, 50, cycles pwm_enable is held low on every stop or direction change (min 1)
WDOG_CYC, 2100000, max cycles in RUN without a pwm_flag before FAULT (must exceed one PWM breath period, ~2,000,000)
WDOG_W, 22, watchdog/dead-time counter width; must hold max(WDOG_CYC, DEADTIME_CYC)
REP_W, 8, repetition counter width

Ports:
div100_clk  in  1  block clock, same domain as the PWM stage
s_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE with fault clear
cmd_dir  in  1  initial direction
cmd_speed  in  3  speed level, forwarded on pwm_cnt
cmd_reps  in  REP_W  repetitions; 0 = continuous until stop_req
cmd_pingpong  in  1  1 = toggle direction after each repetition
stop_req  in  1  level, abort current sequence
fault_clr  in  1  clears FAULT, returns to IDLE
pwm_flag  in  1  one-cycle pulse from PWM stage per completed breath
pwm_enable  out  1  to PWM stage enable
pwm_direct  out  1  to PWM stage direct
pwm_cnt  out  3  to PWM stage cnt
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on sequence end (normal or aborted)
aborted  out  1  valid with done: 1 = ended by stop_req
fault  out  1  sticky watchdog fault
reps_left  out  REP_W  remaining repetitions (0 in continuous mode)

Behaviour:
- Clock div100_clk; reset s_rst_n asynchronous, active-low. All outputs registered. Reset values: every output 0 except cmd_ready = 1. State = IDLE.
- States: IDLE, RUN, DEAD, FAULT.
- IDLE: cmd_ready = 1. On the edge where cmd_valid && cmd_ready: capture dir/speed/reps/pingpong; reps_left <= cmd_reps; pwm_direct <= cmd_dir; pwm_cnt <= cmd_speed; pwm_enable <= 1; watchdog cleared; go to RUN. pwm_enable is therefore high in the cycle after acceptance.
- RUN, priority high to low:
  1. stop_req: pwm_enable <= 0, go to DEAD with end=1, aborted=1. A pwm_flag in the same cycle is ignored (no decrement).
  2. pwm_flag: watchdog cleared. If reps captured != 0 and reps_left == 1: reps_left <= 0, pwm_enable <= 0, go to DEAD with end=1, aborted=0. Otherwise, decrement reps_left if nonzero. If pingpong, also pwm_enable <= 0, pwm_direct <= ~pwm_direct, go to DEAD with end=0. If not pingpong, stay in RUN with enable held high.
  3. Watchdog reaches WDOG_CYC-1: pwm_enable <= 0, fault <= 1, go to FAULT. A flag in the same cycle wins (rule 2).
- DEAD: dead-time counter runs DEADTIME_CYC cycles with pwm_enable = 0. On expiry:
  - end=1: go to IDLE; done pulses for 1 cycle with aborted valid.
  - end=0: pwm_enable <= 1, watchdog cleared, back to RUN.
  - stop_req seen during DEAD with end=0 sets end=1, aborted=1; the dead time is not restarted.
- FAULT: all pwm_* outputs 0, cmd_ready = 0. fault_clr gives fault <= 0 and next state IDLE. No done pulse.
- Direction only ever changes while pwm_enable = 0, so the PWM stage never sees a live reversal. Dropping enable also resets the PWM stage's internal counters, so each RUN segment starts a fresh breath.
- Counters saturate, never wrap. reps_left is 0 in continuous mode.
- cmd_valid outside IDLE is ignored; no queuing.
- Reset mid-operation: immediate return to reset values; pwm_enable drops asynchronously.

Decomposition:
- Package motor_ctrl_pkg: state enum (IDLE, RUN, DEAD, FAULT), REP_W/WDOG_W defaults, speed-level width constant (3).
- One sub-module, cyc_timer: a loadable down-counter with clear/load/expire outputs. It is instantiated twice, once for the watchdog and once for dead-time.

Test Plan (bench overrides DEADTIME_CYC=4, WDOG_CYC=20; flag model pulses every 10 cycles while enable is high):
- cmd reps=3, dir=1, speed=5, pingpong=0 -> pwm_enable high the cycle after accept; pwm_direct=1, pwm_cnt=5; reps_left 3→2→1→0; enable low after the 3rd flag; done pulse after 4 dead cycles with aborted=0; cmd_ready back to 1.
- cmd reps=2, dir=0, pingpong=1 -> after flag 1, enable low for exactly 4 cycles; pwm_direct toggles to 1 only while enable is low; 2nd run ends with done, aborted=0.
- cmd reps=0 (continuous), stop_req raised at cycle 35 -> reps_left stays 0; enable low next edge; done + aborted=1 after 4 cycles; stop and flag in the same cycle -> no decrement.
- Flag model disabled in RUN -> fault=1 and pwm_enable=0 at watchdog cycle 19; cmd_ready=0; cmd_valid ignored; fault_clr -> IDLE, cmd_ready=1, no done.
- Flag arrives exactly in the watchdog-expiry cycle -> no fault, watchdog restarts.
- s_rst_n asserted in RUN and in DEAD -> all outputs immediately at reset values; cmd_ready=1 after release.
